// File: rtl/fir_mac_scheduler_if.sv
// fir_mac_scheduler_if: sample/coefficient handshake and result bus of the FIR MAC scheduler
interface fir_mac_scheduler_if #(
  parameter int BW_in  = 6,
  parameter int BW_out = 8
);
  logic                     in_valid;
  logic signed [BW_in-1:0]  in_data;
  logic                     in_ready;
  logic                     reload;
  logic                     out_valid;
  logic        [BW_out-1:0] out_data;
  logic                     busy;
  modport master (output in_valid, in_data, reload, input in_ready, out_valid, out_data, busy);
  modport slave  (input in_valid, in_data, reload, output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler: FIR filter time-multiplexing one multiplier and one accumulator over all taps
module fir_mac_scheduler #(
  parameter int N_TAPS = 6,
  parameter int BW_in  = 6,
  parameter int BW_sum = 15,
  parameter int BW_out = 8
) (
  input logic                clk,
  input logic                reset,
  fir_mac_scheduler_if.slave bus
);
  localparam int CW = $clog2(N_TAPS + 1);
  typedef enum logic [1:0] {LOAD, IDLE, MAC, OUT} state_t;
  state_t                   r_state;
  logic [CW-1:0]            r_cnt;
  logic signed [BW_in-1:0]  r_c [N_TAPS];
  logic signed [BW_in-1:0]  r_x [N_TAPS];
  logic signed [BW_sum-1:0] r_acc;
  logic                     r_pend;
  logic                     r_out_valid;
  logic [BW_out-1:0]        r_out_data;
  logic signed [2*BW_in-1:0] w_prod;
  logic                     w_xfer;
  assign w_prod        = r_c[r_cnt] * r_x[r_cnt];
  assign bus.in_ready  = (r_state == LOAD || r_state == IDLE) && !r_pend;
  assign bus.busy      = r_state == MAC || r_state == OUT;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign w_xfer        = bus.in_valid && bus.in_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= LOAD;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_pend      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      for (int k = 0; k < N_TAPS; k++) begin
        r_c[k] <= '0;
        r_x[k] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      if (bus.reload && r_state != LOAD) r_pend <= 1'b1;
      case (r_state)
        LOAD: begin
          if (w_xfer) begin
            for (int k = N_TAPS - 1; k > 0; k--) r_c[k] <= r_c[k-1];
            r_c[0] <= bus.in_data;
          end
          if (bus.reload) r_cnt <= w_xfer ? CW'(1) : '0;
          else if (w_xfer && r_cnt == CW'(N_TAPS - 1)) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (w_xfer) r_cnt <= r_cnt + 1'b1;
        end
        IDLE: begin
          if (r_pend) begin
            r_state <= LOAD;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) r_x[k] <= '0;
          end else if (w_xfer) begin
            for (int k = N_TAPS - 1; k > 0; k--) r_x[k] <= r_x[k-1];
            r_x[0]  <= bus.in_data;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= MAC;
          end
        end
        MAC: begin
          r_acc <= r_acc + BW_sum'(w_prod);
          if (r_cnt == CW'(N_TAPS - 1)) begin
            r_cnt   <= '0;
            r_state <= OUT;
          end else r_cnt <= r_cnt + 1'b1;
        end
        OUT: begin
          r_out_data  <= r_acc[BW_out-1:0];
          r_out_valid <= 1'b1;
          // a reload seen during MAC/OUT skips IDLE and goes straight to LOAD
          if (r_pend || bus.reload) begin
            r_state <= LOAD;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) r_x[k] <= '0;
          end else r_state <= IDLE;
        end
        default: r_state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_scheduler.sv
// tb_fir_mac_scheduler: directed vectors with hand-computed results for fir_mac_scheduler
module tb_fir_mac_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int bad_ready = 0;
  logic [7:0] q_d [$];
  int q_c [$];
  fir_mac_scheduler_if bus ();
  fir_mac_scheduler dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.out_valid) begin
      q_d.push_back(bus.out_data);
      q_c.push_back(cyc);
    end
    if (bus.busy && bus.in_ready) bad_ready = bad_ready + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.reload = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q_d.delete();
    q_c.delete();
  endtask
  task automatic xfer(input int v, output int t);
    int n;
    n = 0;
    t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = 6'(v);
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("xfer_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      t = cyc;
      #1 bus.in_valid = 1'b0;
    end
  endtask
  task automatic load6(input int v);
    int t;
    for (int i = 0; i < 6; i++) xfer(v, t);
  endtask
  task automatic expect_out(input int t, input logic [7:0] exp, input string tag);
    int n;
    logic [7:0] d;
    int c;
    n = 0;
    while (q_d.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q_d.size() == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    else begin
      d = q_d.pop_front();
      c = q_c.pop_front();
      check(tag, 32'(d), 32'(exp));
      check({tag, "_lat"}, c - t, 32'd8);
      repeat (2) @(negedge clk);
      check({tag, "_width"}, q_d.size(), 32'd0);
    end
  endtask
  task automatic sample(input int v, input logic [7:0] exp, input string tag);
    int t;
    xfer(v, t);
    @(negedge clk);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_rdy_lo"}, 32'(bus.in_ready), 32'd0);
    expect_out(t, exp, tag);
  endtask
  initial begin
    int t;
    int tp;
    int ts [7];
    logic [7:0] exp_sum [7];
    logic [7:0] exp_wrap [6];
    logic [7:0] d;
    int c;
    exp_sum = '{8'd1, 8'd3, 8'd6, 8'd10, 8'd15, 8'd21, 8'd27};
    exp_wrap = '{8'hC1, 8'h82, 8'h43, 8'h04, 8'hC5, 8'h86};
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.reload = 1'b0;
    do_reset();
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 5; i++) xfer(0, t);
    xfer(1, t);
    sample(5, 8'h05, "imp_pos");
    sample(-3, 8'hFD, "imp_neg");
    do_reset();
    load6(1);
    tp = 0;
    for (int i = 0; i < 7; i++) begin
      xfer(i + 1, ts[i]);
      if (i > 0) begin
        check("sum_rate", ts[i] - tp, 32'd8);
        if (q_d.size() == 0) check("sum_missing", 32'd0, 32'd1);
        else begin
          d = q_d.pop_front();
          c = q_c.pop_front();
          check("sum_data", 32'(d), 32'(exp_sum[i-1]));
          check("sum_lat", c - tp, 32'd8);
        end
      end
      tp = ts[i];
    end
    expect_out(ts[6], exp_sum[6], "sum_last");
    check("sum_ready_vs_busy", bad_ready, 32'd0);
    do_reset();
    load6(31);
    for (int i = 0; i < 6; i++) sample(31, exp_wrap[i], "wrap");
    xfer(31, t);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_data", 32'(bus.out_data), 32'd0);
    repeat (12) @(negedge clk);
    check("midrst_no_out", q_d.size(), 32'd0);
    xfer(5, t);
    repeat (12) @(negedge clk);
    check("midrst_not_sample", q_d.size(), 32'd0);
    check("midrst_still_load", 32'(bus.in_ready), 32'd1);
    do_reset();
    load6(1);
    sample(2, 8'd2, "rl_pre1");
    sample(3, 8'd5, "rl_pre2");
    xfer(10, t);
    repeat (2) @(negedge clk);
    bus.reload = 1'b1;
    @(posedge clk);
    #1 bus.reload = 1'b0;
    expect_out(t, 8'd15, "rl_inflight");
    check("rl_load_ready", 32'(bus.in_ready), 32'd1);
    load6(1);
    sample(4, 8'd4, "rl_hist_clear");
    check("ready_vs_busy", bad_ready, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fir_mac_scheduler.md
FIR_MAC_SCHEDULER -- requirements
Module: fir_mac_scheduler

Interface
REQ-001 SHALL have parameter N_TAPS, default 6, number of filter taps.
REQ-002 SHALL have parameter BW_in, default 6, signed sample and coefficient width.
REQ-003 SHALL have parameter BW_sum, default 15, signed accumulator width.
REQ-004 SHALL have parameter BW_out, default 8, output width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1, data offered on in_data.
REQ-008 SHALL have port in_data, input, BW_in, signed coefficient (LOAD) or sample (IDLE).
REQ-009 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-010 SHALL have port reload, input, 1, request to reload all coefficients.
REQ-011 SHALL have port out_valid, output, 1, one-cycle pulse, out_data holds a new result.
REQ-012 SHALL have port out_data, output, BW_out, filter result.
REQ-013 SHALL have port busy, output, 1, high in MAC and OUT states.

Function
REQ-014 SHALL use one shared signed multiplier and one BW_sum accumulator, time-multiplexed over all taps.
REQ-015 SHALL implement states LOAD, IDLE, MAC, OUT; in_ready = (state is LOAD or IDLE) and no reload pending; in_ready SHALL NOT depend combinationally on any input.
REQ-016 A transfer SHALL occur only on a rising edge with in_valid and in_ready both high; in_valid while in_ready is low is ignored.
REQ-017 In LOAD, each transfer shifts coefficients c[k] <= c[k-1], c[0] <= in_data; after the N_TAPS-th transfer the state SHALL become IDLE (first value loaded ends in c[N_TAPS-1]).
REQ-018 In IDLE, a transfer shifts history x[k] <= x[k-1], x[0] <= in_data, clears the accumulator, and moves to MAC.
REQ-019 MAC SHALL last exactly N_TAPS cycles, tap index i = 0..N_TAPS-1, adding c[i]*x[i] (full-precision product, sign-extended) to the accumulator each cycle.
REQ-020 Accumulation SHALL be two's complement modulo 2^BW_sum; no saturation.
REQ-021 After the last MAC cycle the state SHALL be OUT for one cycle with out_valid=1 and out_data = accumulator[BW_out-1:0], then IDLE.
REQ-022 Latency: transfer at edge T -> out_valid high in the cycle after edge T+N_TAPS+1 (i.e., for N_TAPS=6, the 8th cycle after transfer); max throughput one sample per N_TAPS+2 cycles.
REQ-023 out_data SHALL hold its value until the next OUT state.
REQ-024 reload high in any cycle outside LOAD SHALL set reload_pending; in-flight MAC/OUT completes normally; on entering or being in IDLE with reload_pending, the state SHALL become LOAD, with coefficient count and history x[] cleared and reload_pending cleared.
REQ-025 reload and in_valid together in IDLE: sample transfer is taken, result delivered, then LOAD.
REQ-026 reload while in LOAD SHALL restart the coefficient count at 0.

Reset
REQ-027 reset SHALL, on the next edge, force state LOAD, coefficient count 0, all c[] and x[] 0, accumulator 0, reload_pending 0, out_data 0, out_valid 0, busy 0, in_ready 1, regardless of current state (including mid-MAC).

Verification
REQ-028 Reset: after reset edge -> in_ready=1, out_valid=0, out_data=0x00, busy=0; six loads required before any sample is processed.
REQ-029 Impulse coefficients: load 0,0,0,0,0,1 (c[0]=1); sample 5 -> out_data=0x05; sample -3 -> out_data=0xFD; each out_valid exactly 8 cycles after transfer, one cycle wide.
REQ-030 Moving sum: load six 1s; samples 1..7 back-to-back at max rate -> outputs 1,3,6,10,15,21,27 (0x1B); in_ready low during busy.
REQ-031 Wrap/truncation: load six 31s; samples 31 x6 -> outputs 0xC1 (961), 0x82, 0x43, 0x04, 0xC5, 0x86 (5766).
REQ-032 Reset mid-MAC: assert reset on 3rd MAC cycle -> no out_valid, state LOAD, out_data=0x00, a subsequent sample without reloading is not accepted as a sample.
REQ-033 Reload during MAC: pulse reload on MAC cycle 2 -> current result still delivered correctly, then in_ready stays high in LOAD, next six transfers load coefficients, history reads as zeros for the following sample.
